mac_secuenciador: RTL and testbench

Sequential multiply-accumulate controller that drives the accumulator register's write side (`Suma`, `Bandera`) and reads back its registered output (`Acumulado`). Per request it clears the accumulator, walks `TAPS` coefficient/sample pairs one per cycle, then rescales the 2N-bit sum to an N-bit saturated result. It sits between the sample delay line / coefficient store and the filter output stage of the fixed-point FIR datapath.

---
 rtl/mac_secuenciador.sv | 134 +++++++++++++
 tb/tb_mac_secuenciador.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_secuenciador.sv
// mac_secuenciador: sequential multiply-accumulate controller for the FIR datapath.
// Per request it clears the external accumulator, walks TAPS coefficient/sample
// pairs (one per cycle), then rescales the 2N-bit sum to a saturated N-bit result.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; also clears the accumulator via Bandera
//   start      request, sampled only in IDLE
//   Indice     tap index to the sample/coefficient stores (registered)
//   Dato/Coef  signed sample/coefficient for Indice (combinational read)
//   Suma       next accumulator value (combinational)
//   Bandera    accumulator clear (combinational)
//   Acumulado  registered accumulator output
//   Resultado  registered saturated result
//   Listo      one-cycle pulse, Resultado is new
//   Ocupado    high while an operation is in flight
module mac_secuenciador #(
  parameter int unsigned N    = 25,
  parameter int unsigned F    = 16,
  parameter int unsigned TAPS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] Indice,
  input  logic signed [N-1:0]   Dato,
  input  logic signed [N-1:0]   Coef,
  output logic signed [2*N-1:0] Suma,
  output logic                  Bandera,
  input  logic signed [2*N-1:0] Acumulado,
  output logic signed [N-1:0]   Resultado,
  output logic                  Listo,
  output logic                  Ocupado
);

  localparam int unsigned IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PW = 2 * N;

  // Saturation limits expressed at accumulator width.
  localparam logic signed [PW-1:0] SAT_MAX = {{(N + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(N + 1){1'b1}}, {(N - 1){1'b0}}};
  localparam logic [IW-1:0]        LAST_IDX = IW'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    MAC   = 2'd2,
    OUT   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      indice_q, indice_d;
  logic signed [N-1:0] resultado_q, resultado_d;
  logic               listo_q, listo_d;
  logic               ocupado_q, ocupado_d;

  logic signed [PW-1:0] dato_x, coef_x, prod, shifted;

  // Signed N x N product, computed at full 2N width after sign extension.
  always_comb begin
    dato_x = {{N{Dato[N-1]}}, Dato};
    coef_x = {{N{Coef[N-1]}}, Coef};
    prod   = dato_x * coef_x;
  end

  // Arithmetic shift drops the fractional bits, truncating toward -inf.
  always_comb begin
    shifted = Acumulado >>> F;
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      indice_q    <= '0;
      resultado_q <= '0;
      listo_q     <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      indice_q    <= indice_d;
      resultado_q <= resultado_d;
      listo_q     <= listo_d;
      ocupado_q   <= ocupado_d;
    end
  end

  // Next-state, accumulator write side and result datapath.
  always_comb begin
    state_d     = state_q;
    indice_d    = indice_q;
    resultado_d = resultado_q;
    listo_d     = 1'b0;
    Suma        = Acumulado;
    Bandera     = reset;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        Bandera  = 1'b1;
        indice_d = '0;
        state_d  = MAC;
      end
      MAC: begin
        // Reset is synchronous, so the state may still read MAC while reset is high.
        if (!reset) Suma = Acumulado + prod;
        if (indice_q == LAST_IDX) begin
          indice_d = '0;
          state_d  = OUT;
        end else begin
          indice_d = indice_q + IW'(1);
        end
      end
      OUT: begin
        if (shifted > SAT_MAX)      resultado_d = SAT_MAX[N-1:0];
        else if (shifted < SAT_MIN) resultado_d = SAT_MIN[N-1:0];
        else                        resultado_d = shifted[N-1:0];
        listo_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ocupado_d = (state_d != IDLE);
  end

  assign Indice    = indice_q;
  assign Resultado = resultado_q;
  assign Listo     = listo_q;
  assign Ocupado   = ocupado_q;

endmodule

// File: tb/tb_mac_secuenciador.sv
// Testbench for mac_secuenciador: table-driven operations plus hand-written
// reset, ignored-start and held-start sequences. Models the accumulator register
// and the combinational sample/coefficient stores.
module tb_mac_secuenciador;

  localparam int unsigned N    = 25;
  localparam int unsigned F    = 16;
  localparam int unsigned TAPS = 5;
  localparam int unsigned IW   = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [IW-1:0]         Indice;
  logic signed [N-1:0]   Dato;
  logic signed [N-1:0]   Coef;
  logic signed [2*N-1:0] Suma;
  logic                  Bandera;
  logic signed [2*N-1:0] Acumulado;
  logic signed [N-1:0]   Resultado;
  logic                  Listo;
  logic                  Ocupado;

  logic signed [N-1:0] dato_mem [0:TAPS-1];
  logic signed [N-1:0] coef_mem [0:TAPS-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_secuenciador #(.N(N), .F(F), .TAPS(TAPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .Indice    (Indice),
    .Dato      (Dato),
    .Coef      (Coef),
    .Suma      (Suma),
    .Bandera   (Bandera),
    .Acumulado (Acumulado),
    .Resultado (Resultado),
    .Listo     (Listo),
    .Ocupado   (Ocupado)
  );

  // Combinational stores and the accumulator register the block drives.
  assign Dato = dato_mem[Indice];
  assign Coef = coef_mem[Indice];

  always @(posedge clk) begin
    if (Bandera) Acumulado <= '0;
    else         Acumulado <= Suma;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic load(input logic signed [N-1:0] d, input logic signed [N-1:0] c,
                      input bit tap0_only);
    for (int i = 0; i < TAPS; i++) begin
      dato_mem[i] = (tap0_only && i != 0) ? '0 : d;
      coef_mem[i] = (tap0_only && i != 0) ? '0 : c;
    end
  endtask

  // One operation; k counts cycles after the accepting edge E (k=0 is CLEAR).
  // extra_k >= 0 pulses start again during that cycle.
  task automatic run_op(input string nm, input logic signed [N-1:0] exp_res,
                        input int extra_k);
    int  listo_cnt = 0;
    int  listo_k   = -1;
    int  busy_cnt  = 0;
    bit  idx_ok    = 1'b1;
    bit  clr_ok    = 1'b1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k <= TAPS + 6; k++) begin
      start = (k == extra_k);
      #1;
      if (Ocupado) busy_cnt++;
      if (k == 0 && Bandera !== 1'b1) clr_ok = 1'b0;
      if (k >= 1 && k <= TAPS && (Indice !== IW'(k - 1) || Bandera !== 1'b0)) idx_ok = 1'b0;
      if (Listo) begin
        listo_cnt++;
        listo_k = k;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({nm, " result"}, Resultado, exp_res);
    check({nm, " listo_count"}, listo_cnt, 1);
    check({nm, " listo_latency"}, listo_k, TAPS + 2);
    check({nm, " ocupado_cycles"}, busy_cnt, TAPS + 2);
    check({nm, " indice_seq"}, idx_ok, 1);
    check({nm, " clear_bandera"}, clr_ok, 1);
  endtask

  typedef struct {
    string               name;
    logic signed [N-1:0] dato;
    logic signed [N-1:0] coef;
    bit                  tap0;
    logic signed [N-1:0] exp_res;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"nominal",   65536,     32768,    1'b0, 163840};
    vecs[1] = '{"negative",  -65536,    16384,    1'b0, -81920};
    vecs[2] = '{"trunc",     -1,        1,        1'b1, -1};
    vecs[3] = '{"sat_pos",   16777215,  16777215, 1'b1, 16777215};
    vecs[4] = '{"sat_neg",   -16777216, 16777215, 1'b1, -16777216};
    vecs[5] = '{"ones",      65536,     65536,    1'b0, 327680};
    vecs[6] = '{"mixed",     131072,    -98304,   1'b0, -983040};
    vecs[7] = '{"sat_accum", 6553600,   196608,   1'b0, 16777215};

    reset = 1'b1;
    start = 1'b0;
    load('0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset resultado", Resultado, 0);
    check("reset listo", Listo, 0);
    check("reset ocupado", Ocupado, 0);
    check("reset indice", Indice, 0);
    check("reset bandera", Bandera, 1);
    check("reset suma", Suma, Acumulado);
    @(posedge clk); #1; reset = 1'b0;
    #1;
    check("idle bandera", Bandera, 0);

    foreach (vecs[i]) begin
      load(vecs[i].dato, vecs[i].coef, vecs[i].tap0);
      run_op(vecs[i].name, vecs[i].exp_res, -1);
      check({vecs[i].name, " idle_suma"}, Suma, Acumulado);
    end

    // Second start two cycles after acceptance must be ignored.
    load(65536, 32768, 1'b0);
    run_op("ignored_start", 163840, 2);

    // Reset held three cycles mid-MAC aborts the operation.
    begin
      bit rst_ok = 1'b1;
      int stray  = 0;
      load(65536, 65536, 1'b0);
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      if (Bandera !== 1'b1 || Suma !== Acumulado) rst_ok = 1'b0;
      for (int r = 0; r < 3; r++) begin
        @(posedge clk); #1;
        if (Resultado !== '0 || Listo !== 1'b0 || Ocupado !== 1'b0 ||
            Bandera !== 1'b1 || Acumulado !== '0) rst_ok = 1'b0;
      end
      reset = 1'b0;
      for (int r = 0; r < 12; r++) begin
        @(posedge clk); #1;
        if (Listo) stray++;
      end
      check("midmac_reset outputs", rst_ok, 1);
      check("midmac_reset no_listo", stray, 0);
      check("midmac_reset resultado", Resultado, 0);
      run_op("after_reset", 327680, -1);
    end

    // Start held high for three operations: pulses every TAPS+3 cycles.
    begin
      int  n_listo = 0;
      int  ks [$];
      bit  res_ok = 1'b1;
      load(65536, 65536, 1'b0);
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k <= 30; k++) begin
        if (k == 17) start = 1'b0;
        if (Listo) begin
          n_listo++;
          ks.push_back(k);
          if (Resultado !== 25'sd327680) res_ok = 1'b0;
        end
        @(posedge clk); #1;
      end
      check("held listo_count", n_listo, 3);
      if (ks.size() == 3) begin
        check("held first_k", ks[0], TAPS + 2);
        check("held spacing1", ks[1] - ks[0], TAPS + 3);
        check("held spacing2", ks[2] - ks[1], TAPS + 3);
      end
      check("held results", res_ok, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
